alu_arbiter: RTL

- Shares the single-cycle ALU between two requesters: requester 0 (main pipeline execute stage) and requester 1 (auxiliary unit, e.g. address generation or debug).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The arbiter selects one request per cycle, drives the ALU operands combinationally, and captures the ALU result into that requester's 1-entry response buffer.
- Arbitration is round-robin or fixed-priority, with a starvation guard in fixed-priority mode.

---
 rtl/alu_arbiter_if.sv | 57 +++++
 rtl/alu_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of request/response channels for both requesters plus the shared ALU bus.
// The slave modport is the arbiter. The master modport is the surrounding requesters and the ALU.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [5:0]  req0_func;
  logic [5:0]  req1_func;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req0_upper;
  logic        req1_upper;

  logic        resp0_valid;
  logic        resp1_valid;
  logic        resp0_ready;
  logic        resp1_ready;
  logic [31:0] resp0_result;
  logic [31:0] resp1_result;
  logic        resp0_branch;
  logic        resp0_jump;
  logic        resp1_branch;
  logic        resp1_jump;

  logic [5:0]  alu_func;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_upper;
  logic [31:0] alu_result;
  logic        alu_branch;
  logic        alu_jump;

  modport slave (
    input  req0_valid, req1_valid, req0_func, req1_func,
    input  req0_a, req0_b, req1_a, req1_b, req0_upper, req1_upper,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp0_result, resp1_result,
    output resp0_branch, resp0_jump, resp1_branch, resp1_jump,
    input  resp0_ready, resp1_ready,
    output alu_func, alu_a, alu_b, alu_upper,
    input  alu_result, alu_branch, alu_jump
  );

  modport master (
    output req0_valid, req1_valid, req0_func, req1_func,
    output req0_a, req0_b, req1_a, req1_b, req0_upper, req1_upper,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp0_result, resp1_result,
    input  resp0_branch, resp0_jump, resp1_branch, resp1_jump,
    output resp0_ready, resp1_ready,
    input  alu_func, alu_a, alu_b, alu_upper,
    output alu_result, alu_branch, alu_jump
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single-cycle ALU, with a 1-entry response buffer per requester.
// Arbitration is round-robin, or fixed priority with a starvation guard for requester 1.
module alu_arbiter #(
  parameter bit          RR_ENABLE = 1'b1,
  parameter int unsigned MAX_WAIT  = 3
) (
  input logic          clk,
  input logic          reset_n,
  alu_arbiter_if.slave bus
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic        last_grant;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_cnt_nxt;
  logic        elig0;
  logic        elig1;
  logic        grant0;
  logic        grant1;

  logic        r0_valid;
  logic        r1_valid;
  logic [31:0] r0_result;
  logic [31:0] r1_result;
  logic        r0_branch;
  logic        r0_jump;
  logic        r1_branch;
  logic        r1_jump;

  // reset_n gates eligibility so the ready outputs drop as soon as reset is asserted
  always_comb begin
    elig0  = reset_n & bus.req0_valid & (~r0_valid | bus.resp0_ready);
    elig1  = reset_n & bus.req1_valid & (~r1_valid | bus.resp1_ready);
    grant1 = elig1;
    if (elig0 && elig1) begin
      if (RR_ENABLE) grant1 = (last_grant == 1'b0);
      else           grant1 = (wait_cnt == WAIT_LIMIT);
    end
    grant0 = elig0 & ~grant1;
  end

  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (RR_ENABLE || !bus.req1_valid || grant1)
      wait_cnt_nxt = 4'd0;
    else if (elig1 && (wait_cnt != WAIT_LIMIT))
      wait_cnt_nxt = wait_cnt + 4'd1;
  end

  always_comb begin
    bus.alu_func  = 6'b000000;
    bus.alu_a     = 32'd0;
    bus.alu_b     = 32'd0;
    bus.alu_upper = 1'b0;
    if (grant0) begin
      bus.alu_func  = bus.req0_func;
      bus.alu_a     = bus.req0_a;
      bus.alu_b     = bus.req0_b;
      bus.alu_upper = bus.req0_upper;
    end else if (grant1) begin
      bus.alu_func  = bus.req1_func;
      bus.alu_a     = bus.req1_a;
      bus.alu_b     = bus.req1_b;
      bus.alu_upper = bus.req1_upper;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      wait_cnt   <= 4'd0;
    end else begin
      if (grant0)      last_grant <= 1'b0;
      else if (grant1) last_grant <= 1'b1;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Payload is only written on accept, so it holds while the consumer stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r0_valid  <= 1'b0;
      r0_result <= 32'd0;
      r0_branch <= 1'b0;
      r0_jump   <= 1'b0;
    end else if (grant0) begin
      r0_valid  <= 1'b1;
      r0_result <= bus.alu_result;
      r0_branch <= bus.alu_branch;
      r0_jump   <= bus.alu_jump;
    end else if (bus.resp0_ready) begin
      r0_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r1_valid  <= 1'b0;
      r1_result <= 32'd0;
      r1_branch <= 1'b0;
      r1_jump   <= 1'b0;
    end else if (grant1) begin
      r1_valid  <= 1'b1;
      r1_result <= bus.alu_result;
      r1_branch <= bus.alu_branch;
      r1_jump   <= bus.alu_jump;
    end else if (bus.resp1_ready) begin
      r1_valid  <= 1'b0;
    end
  end

  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.resp0_valid  = r0_valid;
  assign bus.resp1_valid  = r1_valid;
  assign bus.resp0_result = r0_result;
  assign bus.resp1_result = r1_result;
  assign bus.resp0_branch = r0_branch;
  assign bus.resp0_jump   = r0_jump;
  assign bus.resp1_branch = r1_branch;
  assign bus.resp1_jump   = r1_jump;

endmodule
